// File: rtl/muldiv_pkg.sv
// Shared types and helpers for the iterative RV32M multiply/divide unit.
// Optional feature macro: MULDIV_FAST_MUL_EN (see muldiv_iter.sv).
package muldiv_pkg;

    localparam int XLEN_DEFAULT = 32;

    // funct3 encoding of the M-extension ops
    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } muldiv_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } muldiv_state_e;

    // Divide and remainder ops all have funct3[2] set
    function automatic logic is_div(input muldiv_op_e op);
        return op[2];
    endfunction

    // Operand A is treated as signed by MULH, MULHSU, DIV and REM
    function automatic logic a_is_signed(input muldiv_op_e op);
        return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
    endfunction

    // Operand B is treated as signed by MULH, DIV and REM
    function automatic logic b_is_signed(input muldiv_op_e op);
        return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    endfunction

endpackage

// File: rtl/muldiv_if.sv
// Request/response bundle between the core and the multiply/divide unit.
interface muldiv_if
    import muldiv_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) ();
    logic            start_i;
    logic [2:0]      op_i;
    logic [XLEN-1:0] rs1_i;
    logic [XLEN-1:0] rs2_i;
    logic            flush_i;
    logic            busy_o;
    logic            done_o;
    logic [XLEN-1:0] result_o;
    logic            div_zero_o;

    // Core side issues requests and observes completion
    modport master (
        output start_i, op_i, rs1_i, rs2_i, flush_i,
        input  busy_o, done_o, result_o, div_zero_o
    );

    // Unit side
    modport slave (
        input  start_i, op_i, rs1_i, rs2_i, flush_i,
        output busy_o, done_o, result_o, div_zero_o
    );
endinterface

// File: rtl/muldiv_sign_fix.sv
// Sign handling around the unsigned datapath: operand magnitude extraction
// on the way in, negation and result selection on the way out.
module muldiv_sign_fix
    import muldiv_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  muldiv_op_e        op_in,
    input  logic [XLEN-1:0]   rs1,
    input  logic [XLEN-1:0]   rs2,
    output logic [XLEN-1:0]   a_mag,
    output logic [XLEN-1:0]   b_mag,
    output logic              a_neg,
    output logic              b_neg,
    input  muldiv_op_e        fix_op,
    input  logic              fix_a_neg,
    input  logic              fix_b_neg,
    input  logic [2*XLEN-1:0] fix_acc,
    output logic [XLEN-1:0]   fix_result
);
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quo;
    logic [XLEN-1:0]   rem;

    // Magnitudes of the operands for the signedness the op implies
    always_comb begin
        a_neg = a_is_signed(op_in) & rs1[XLEN-1];
        b_neg = b_is_signed(op_in) & rs2[XLEN-1];
        a_mag = a_neg ? -rs1 : rs1;
        b_mag = b_neg ? -rs2 : rs2;
    end

    // Restore signs and pick the half of the accumulator the op returns
    always_comb begin
        // NOTE: every output gets a value before the case, so no latch can be inferred.
        fix_result = '0;
        prod       = (fix_a_neg ^ fix_b_neg) ? -fix_acc : fix_acc;
        quo        = (fix_a_neg ^ fix_b_neg) ? -fix_acc[XLEN-1:0] : fix_acc[XLEN-1:0];
        rem        = fix_a_neg ? -fix_acc[2*XLEN-1:XLEN] : fix_acc[2*XLEN-1:XLEN];
        unique case (fix_op)
            OP_MUL:                       fix_result = prod[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: fix_result = prod[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:              fix_result = quo;
            OP_REM, OP_REMU:              fix_result = rem;
        endcase
    end

endmodule

// File: rtl/muldiv_iter.sv
// Iterative RV32M multiply/divide unit with start/done handshake and flush.
// Optional feature macro: MULDIV_FAST_MUL_EN -- when defined, multiplies use a
// combinational product and complete in one cycle; divides stay iterative.
module muldiv_iter
    import muldiv_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input logic     clk,
    input logic     rst_n,
    muldiv_if.slave bus
);
    localparam int CNT_W = $clog2(XLEN);

    muldiv_state_e     state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0]   b_q, b_d;
    muldiv_op_e        op_q, op_d;
    logic              a_neg_q, a_neg_d;
    logic              b_neg_q, b_neg_d;
    logic [XLEN-1:0]   result_q, result_d;
    logic              div_zero_q, div_zero_d;

    muldiv_op_e        op_in;
    logic [XLEN-1:0]   a_mag, b_mag;
    logic              a_neg, b_neg;
    logic              busy;
    muldiv_op_e        fix_op;
    logic              fix_a_neg, fix_b_neg;
    logic [2*XLEN-1:0] fix_acc;
    logic [XLEN-1:0]   fix_result;
    logic [XLEN:0]     mul_sum;
    logic [XLEN:0]     div_shift;
    logic [XLEN:0]     div_diff;
    logic [2*XLEN-1:0] step_acc;
    logic              overflow;

    assign op_in = muldiv_op_e'(bus.op_i);
    assign busy  = (state_q == CALC) || (state_q == FIX);

    muldiv_sign_fix #(.XLEN(XLEN)) u_sign_fix (
        .op_in      (op_in),
        .rs1        (bus.rs1_i),
        .rs2        (bus.rs2_i),
        .a_mag      (a_mag),
        .b_mag      (b_mag),
        .a_neg      (a_neg),
        .b_neg      (b_neg),
        .fix_op     (fix_op),
        .fix_a_neg  (fix_a_neg),
        .fix_b_neg  (fix_b_neg),
        .fix_acc    (fix_acc),
        .fix_result (fix_result)
    );

    // Sign-fix stage serves FIX; outside CALC/FIX it can serve the fast multiplier
    always_comb begin
`ifdef MULDIV_FAST_MUL_EN
        fix_op    = busy ? op_q : op_in;
        fix_a_neg = busy ? a_neg_q : a_neg;
        fix_b_neg = busy ? b_neg_q : b_neg;
        fix_acc   = busy ? acc_q : ({{XLEN{1'b0}}, a_mag} * {{XLEN{1'b0}}, b_mag});
`else
        fix_op    = op_q;
        fix_a_neg = a_neg_q;
        fix_b_neg = b_neg_q;
        fix_acc   = acc_q;
`endif
    end

    // One radix-2 step: shift-add for multiply, restoring shift-subtract for divide
    always_comb begin
        mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, (acc_q[0] ? b_q : {XLEN{1'b0}})};
        div_shift = acc_q[2*XLEN-1:XLEN-1];
        div_diff  = div_shift - {1'b0, b_q};
        if (is_div(op_q)) begin
            if (!div_diff[XLEN]) step_acc = {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
            else                 step_acc = {div_shift[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
        end else begin
            step_acc = {mul_sum, acc_q[XLEN-1:1]};
        end
    end

    assign overflow = ((op_in == OP_DIV) || (op_in == OP_REM))
                   && (bus.rs1_i == {1'b1, {(XLEN-1){1'b0}}})
                   && (bus.rs2_i == {XLEN{1'b1}});

    // Next-state and datapath control
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        b_d        = b_q;
        op_d       = op_q;
        a_neg_d    = a_neg_q;
        b_neg_d    = b_neg_q;
        result_d   = result_q;
        div_zero_d = div_zero_q;
        unique case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (bus.start_i) begin
                    op_d    = op_in;
                    a_neg_d = a_neg;
                    b_neg_d = b_neg;
                    acc_d   = {{XLEN{1'b0}}, a_mag};
                    b_d     = b_mag;
                    cnt_d   = CNT_W'(XLEN - 1);
                    state_d = CALC;
                    if (is_div(op_in) && (bus.rs2_i == '0)) begin
                        result_d   = ((op_in == OP_DIV) || (op_in == OP_DIVU)) ? {XLEN{1'b1}} : bus.rs1_i;
                        div_zero_d = 1'b1;
                        state_d    = DONE;
                    end else if (overflow) begin
                        result_d   = (op_in == OP_DIV) ? bus.rs1_i : '0;
                        div_zero_d = 1'b0;
                        state_d    = DONE;
                    end
`ifdef MULDIV_FAST_MUL_EN
                    else if (!is_div(op_in)) begin
                        result_d   = fix_result;
                        div_zero_d = 1'b0;
                        state_d    = DONE;
                    end
`endif
                end
            end
            CALC: begin
                acc_d = step_acc;
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == '0) state_d = FIX;
            end
            FIX: begin
                result_d   = fix_result;
                div_zero_d = 1'b0;
                state_d    = DONE;
            end
        endcase
        // Flush aborts whatever is in flight and leaves the last result visible
        if (bus.flush_i) begin
            state_d    = IDLE;
            result_d   = result_q;
            div_zero_d = div_zero_q;
        end
    end

    // State and datapath registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            acc_q      <= '0;
            b_q        <= '0;
            op_q       <= OP_MUL;
            a_neg_q    <= 1'b0;
            b_neg_q    <= 1'b0;
            result_q   <= '0;
            div_zero_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            b_q        <= b_d;
            op_q       <= op_d;
            a_neg_q    <= a_neg_d;
            b_neg_q    <= b_neg_d;
            result_q   <= result_d;
            div_zero_q <= div_zero_d;
        end
    end

    assign bus.busy_o     = busy;
    assign bus.done_o     = (state_q == DONE);
    assign bus.result_o   = result_q;
    assign bus.div_zero_o = div_zero_q;

endmodule

// File: tb/tb_muldiv_iter.sv
// Self-checking bench for muldiv_iter: directed cases plus randomized ops
// compared against an arithmetic reference model.
module tb_muldiv_iter;
    localparam int XLEN = 32;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    logic [XLEN-1:0] last_res = '0;
    logic            last_dz  = 1'b0;

    muldiv_if #(.XLEN(XLEN)) bus ();

    muldiv_iter #(.XLEN(XLEN)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Multiplies finish in one cycle when the fast multiplier is built in
    function automatic logic fast_mul(input logic [2:0] op);
`ifdef MULDIV_FAST_MUL_EN
        return !op[2];
`else
        return 1'b0;
`endif
    endfunction

    // RV32M semantics in plain arithmetic
    function automatic void ref_model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                      output logic [31:0] res, output logic dz, output logic early);
        logic [63:0] p;
        longint      sa, sb, ub;
        int          sq;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ub = longint'({32'b0, b});
        dz = 1'b0;
        early = fast_mul(op);
        res = '0;
        case (op)
            3'd0: begin p = {32'b0, a} * {32'b0, b}; res = p[31:0];  end
            3'd1: begin p = sa * sb;                 res = p[63:32]; end
            3'd2: begin p = sa * ub;                 res = p[63:32]; end
            3'd3: begin p = {32'b0, a} * {32'b0, b}; res = p[63:32]; end
            3'd4, 3'd6: begin
                if (b == 0) begin
                    early = 1'b1; dz = 1'b1;
                    res = (op == 3'd4) ? 32'hFFFF_FFFF : a;
                end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    early = 1'b1;
                    res = (op == 3'd4) ? a : 32'h0;
                end else begin
                    sq = (op == 3'd4) ? ($signed(a) / $signed(b)) : ($signed(a) % $signed(b));
                    res = sq;
                end
            end
            default: begin
                if (b == 0) begin
                    early = 1'b1; dz = 1'b1;
                    res = (op == 3'd5) ? 32'hFFFF_FFFF : a;
                end else begin
                    res = (op == 3'd5) ? (a / b) : (a % b);
                end
            end
        endcase
    endfunction

    // Present a request at the next edge; returns at the negedge after T0
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.start_i = 1'b1;
        bus.op_i    = op;
        bus.rs1_i   = a;
        bus.rs2_i   = b;
        @(posedge clk);
        @(negedge clk);
        bus.start_i = 1'b0;
    endtask

    // Wait (bounded) for done_o and check latency, busy length and result
    task automatic wait_done(input string tag, input logic [31:0] exp_res, input logic exp_dz, input logic early);
        int n = 1;
        int busy_cnt = 0;
        while (!bus.done_o && n < 200) begin
            if (bus.busy_o) busy_cnt++;
            @(negedge clk);
            n++;
        end
        check({tag, " done"}, bus.done_o, 1);
        check({tag, " latency"}, n, early ? 1 : XLEN + 2);
        check({tag, " busy"}, busy_cnt, early ? 0 : XLEN + 1);
        check({tag, " result"}, bus.result_o, exp_res);
        check({tag, " div_zero"}, bus.div_zero_o, exp_dz);
        last_res = exp_res;
        last_dz  = exp_dz;
    endtask

    task automatic run(input string tag, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp_res, input logic exp_dz, input logic early);
        issue(op, a, b);
        wait_done(tag, exp_res, exp_dz, early | fast_mul(op));
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 7))
            0:       return 32'h0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return $urandom_range(0, 15);
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [31:0] r_res;
        logic        r_dz;
        logic        r_early;
        logic [2:0]  r_op;
        logic [31:0] r_a, r_b;
        int          dones;

        bus.start_i = 1'b0;
        bus.op_i    = '0;
        bus.rs1_i   = '0;
        bus.rs2_i   = '0;
        bus.flush_i = 1'b0;
        repeat (3) @(negedge clk);
        check("reset busy", bus.busy_o, 0);
        check("reset done", bus.done_o, 0);
        check("reset result", bus.result_o, 0);
        check("reset div_zero", bus.div_zero_o, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Multiplies
        run("mul", 3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0, 1'b0);
        @(negedge clk);
        check("mul pulse", bus.done_o, 0);
        run("mulh", 3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1'b0, 1'b0);
        run("mulhu", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, 1'b0);
        run("mulhsu", 3'd2, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 1'b0, 1'b0);

        // Divides
        run("div", 3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b0, 1'b0);
        run("rem", 3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 1'b0, 1'b0);
        run("divu", 3'd5, 32'd100, 32'd7, 32'd14, 1'b0, 1'b0);
        run("remu", 3'd7, 32'd100, 32'd7, 32'd2, 1'b0, 1'b0);

        // Early completion
        run("div0", 3'd4, 32'd5, 32'd0, 32'hFFFF_FFFF, 1'b1, 1'b1);
        run("remu0", 3'd7, 32'd5, 32'd0, 32'd5, 1'b1, 1'b1);
        run("div ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 1'b1);
        run("rem ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 1'b0, 1'b1);
        run("divu 7", 3'd5, 32'd49, 32'd7, 32'd7, 1'b0, 1'b0);

        // Flush at T0+10: no done, result held
        issue(3'd5, 32'd1000, 32'd3);
        repeat (9) @(negedge clk);
        bus.flush_i = 1'b1;
        @(negedge clk);
        bus.flush_i = 1'b0;
        check("flush busy", bus.busy_o, 0);
        check("flush done", bus.done_o, 0);
        dones = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.done_o) dones++;
        end
        check("flush no done", dones, 0);
        check("flush result held", bus.result_o, last_res);
        check("flush div_zero held", bus.div_zero_o, last_dz);
        run("mul after flush", 3'd0, 32'd3, 32'd4, 32'd12, 1'b0, 1'b0);

        // Flush and start together: start dropped
        bus.flush_i = 1'b1;
        issue(3'd5, 32'd1000, 32'd3);
        bus.flush_i = 1'b0;
        check("flush+start busy", bus.busy_o, 0);
        check("flush+start done", bus.done_o, 0);

        // Reset at T0+5 mid-operation
        issue(3'd7, 32'd12345, 32'd10);
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst busy", bus.busy_o, 0);
        check("midrst done", bus.done_o, 0);
        check("midrst result", bus.result_o, 0);
        check("midrst div_zero", bus.div_zero_o, 0);
        rst_n = 1'b1;
        last_res = '0;
        last_dz  = 1'b0;
        @(negedge clk);

        // start_i held high while busy with changing operands: ignored
        bus.start_i = 1'b1;
        bus.op_i    = 3'd5;
        bus.rs1_i   = 32'd1000;
        bus.rs2_i   = 32'd7;
        @(posedge clk);
        dones = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!bus.busy_o) begin
                bus.start_i = 1'b0;
                break;
            end
            bus.op_i  = 3'($urandom);
            bus.rs1_i = $urandom;
            bus.rs2_i = $urandom;
        end
        check("hold result", bus.result_o, 32'd142);
        for (int i = 0; i < 40; i++) begin
            if (bus.done_o) dones++;
            @(negedge clk);
        end
        check("hold one done", dones, 1);

        // Back-to-back: new start accepted in the DONE cycle
        run("b2b first", 3'd7, 32'd100, 32'd7, 32'd2, 1'b0, 1'b0);
        run("b2b second", 3'd0, 32'd3, 32'd4, 32'd12, 1'b0, 1'b0);

        // Randomized ops against the reference model
        for (int i = 0; i < 40; i++) begin
            r_op = 3'($urandom_range(0, 7));
            r_a  = pick_operand();
            r_b  = pick_operand();
            ref_model(r_op, r_a, r_b, r_res, r_dz, r_early);
            issue(r_op, r_a, r_b);
            wait_done($sformatf("rnd%0d op%0d", i, r_op), r_res, r_dz, r_early);
            @(negedge clk);
            check($sformatf("rnd%0d pulse", i), bus.done_o, 0);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
